// File: rtl/block_killer_pkg.sv
// ---------------------------------------------------------------------------
// block_killer_pkg
// Shared encodings for the move-command path between State_Ctrl,
// Keyboard_Ctrl, the move_cmd_scheduler and Game_Ctrl:
//   - command codes carried on cmd_code
//   - game_state encodings driven by State_Ctrl
//   - scheduler FSM states
//   - grav_period(): gravity period for a given level
// ---------------------------------------------------------------------------
package block_killer_pkg;

  localparam logic [1:0] CMD_LEFT    = 2'd0;
  localparam logic [1:0] CMD_RIGHT   = 2'd1;
  localparam logic [1:0] CMD_DOWN    = 2'd2;
  localparam logic [1:0] CMD_GRAVITY = 2'd3;

  localparam logic [1:0] GS_IDLE  = 2'd0;
  localparam logic [1:0] GS_PLAY  = 2'd1;
  localparam logic [1:0] GS_PAUSE = 2'd2;
  localparam logic [1:0] GS_OVER  = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_e;

  // max(tick_div - lvl*lvl_step, min_div) in 32-bit unsigned arithmetic.
  // The reduction is compared against the headroom first so the
  // subtraction can never wrap.
  function automatic logic [31:0] grav_period(input logic [3:0]  lvl,
                                              input logic [31:0] tick_div,
                                              input logic [31:0] lvl_step,
                                              input logic [31:0] min_div);
    logic [31:0] red;
    red = {28'd0, lvl} * lvl_step;
    if (red >= tick_div - min_div) return min_div;
    return tick_div - red;
  endfunction

endpackage

// File: rtl/move_cmd_scheduler_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding 2-bit key command codes.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empties the queue on the next edge
//   push_i, data_i write request and data (ignored when full unless a pop
//                  happens in the same cycle)
//   pop_i          read request (ignored when empty)
//   data_o         current head entry (combinational)
//   full_o,empty_o status flags
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [1:0] data_i,
  output logic [1:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full queue is still legal when the head leaves this cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/move_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// move_cmd_scheduler
// Merges queued keyboard moves and the periodic gravity tick into one
// valid/ready command stream towards Game_Ctrl. Gravity beats queued keys;
// keys leave in arrival order. Gravity speeds up with the level.
// Ports:
//   CLK_50M, RST      clock, synchronous active-high reset
//   game_state        0=IDLE 1=PLAY 2=PAUSE 3=OVER
//   *_key_press       one-cycle key pulses (DOWN > LEFT > RIGHT)
//   level_up          one-cycle pulse, level saturates at 15
//   cmd_valid/code    command to the game core, held until cmd_ready
//   cmd_ready         game core accepts the command
//   level             current level
//   overflow          sticky: a key or gravity tick was dropped
// Build option: define SOFT_DROP_RESET_EN to restart the gravity count
// (and drop any pending tick) whenever a DOWN command is accepted.
// ---------------------------------------------------------------------------
module move_cmd_scheduler
  import block_killer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned LEVEL_STEP = 2000000,
  parameter int unsigned MIN_DIV    = 5000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [1:0] game_state,
  input  logic       left_key_press,
  input  logic       right_key_press,
  input  logic       down_key_press,
  input  logic       level_up,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  input  logic       cmd_ready,
  output logic [3:0] level,
  output logic       overflow
);

  sched_state_e state_q;
  logic         cmd_valid_q;
  logic [1:0]   cmd_code_q;
  logic [3:0]   level_q, level_d;
  logic         overflow_q, overflow_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  period_q;
  logic         grav_pend_q, grav_pend_d;
  logic [1:0]   gs_prev_q;

  logic         in_play, start_play;
  logic         key_any, key_multi, key_push;
  logic [1:0]   key_code;
  logic         tick_fire, sel_grav, fifo_pop;
  logic         fifo_full, fifo_empty;
  logic [1:0]   fifo_head;

  assign in_play    = (game_state == GS_PLAY);
  assign start_play = (gs_prev_q == GS_IDLE) && in_play;

  assign key_any   = left_key_press | right_key_press | down_key_press;
  assign key_multi = (left_key_press & right_key_press) |
                     (left_key_press & down_key_press)  |
                     (right_key_press & down_key_press);
  assign key_push  = in_play && key_any;
  assign key_code  = down_key_press ? CMD_DOWN :
                     left_key_press ? CMD_LEFT : CMD_RIGHT;

  // >= rather than == so a period that shrinks below the running count
  // fires on the next cycle instead of wrapping the full 32-bit range.
  assign tick_fire = in_play && (cnt_q >= period_q - 32'd1);
  assign sel_grav  = (state_q == ST_IDLE) && in_play && grav_pend_q;
  assign fifo_pop  = (state_q == ST_IDLE) && in_play && !grav_pend_q && !fifo_empty;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK_50M),
    .rst_i   (RST),
    .flush_i (!in_play),
    .push_i  (key_push),
    .pop_i   (fifo_pop),
    .data_i  (key_code),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SOFT_DROP_RESET_EN
  logic soft_drop;
  assign soft_drop = in_play && cmd_valid_q && cmd_ready && (cmd_code_q == CMD_DOWN);
`endif

  always_comb begin
    cnt_d = cnt_q;
    case (game_state)
      GS_PLAY:  cnt_d = tick_fire ? 32'd0 : cnt_q + 32'd1;
      GS_PAUSE: cnt_d = cnt_q;
      default:  cnt_d = 32'd0;
    endcase

    grav_pend_d = grav_pend_q;
    if (!in_play) begin
      grav_pend_d = 1'b0;
    end else begin
      if (sel_grav)  grav_pend_d = 1'b0;
      if (tick_fire) grav_pend_d = 1'b1;
    end

`ifdef SOFT_DROP_RESET_EN
    if (soft_drop) begin
      cnt_d       = 32'd0;
      grav_pend_d = 1'b0;
    end
`endif

    level_d = level_q;
    if (level_up && (level_q != 4'd15)) level_d = level_q + 4'd1;
    if (start_play) level_d = 4'd0;

    overflow_d = overflow_q;
    if (start_play) overflow_d = 1'b0;
    // A tick only counts as lost when the pending one is not being
    // consumed on this same edge.
    if (in_play && ((key_any && key_multi) ||
                    (key_push && fifo_full && !fifo_pop) ||
                    (tick_fire && grav_pend_q && !sel_grav)))
      overflow_d = 1'b1;
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      cnt_q       <= 32'd0;
      grav_pend_q <= 1'b0;
      level_q     <= 4'd0;
      overflow_q  <= 1'b0;
      period_q    <= grav_period(4'd0, 32'(TICK_DIV), 32'(LEVEL_STEP), 32'(MIN_DIV));
      gs_prev_q   <= GS_IDLE;
    end else begin
      cnt_q       <= cnt_d;
      grav_pend_q <= grav_pend_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      period_q    <= grav_period(level_q, 32'(TICK_DIV), 32'(LEVEL_STEP), 32'(MIN_DIV));
      gs_prev_q   <= game_state;
    end
  end

  // Issue FSM: one idle cycle between commands, outputs registered.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_LEFT;
    end else if (!in_play) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_grav) begin
            cmd_code_q  <= CMD_GRAVITY;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end else if (fifo_pop) begin
            cmd_code_q  <= fifo_head;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/move_cmd_scheduler.md
Name: move_cmd_scheduler

Overview:
Sequences all piece-move commands into the game core (Game_Ctrl datapath) over a single valid/ready command channel.
- Queues keyboard move pulses and generates the periodic gravity tick.
- Arbitrates the two sources, gravity first; keys are served in arrival order.
- Speeds up gravity per level.
- Sits between Keyboard_Ctrl/State_Ctrl and Game_Ctrl.

Parameters:
TICK_DIV, 25000000, gravity period in clock cycles at level 0
LEVEL_STEP, 2000000, period reduction per level
MIN_DIV, 5000000, floor of gravity period
FIFO_DEPTH, 4, key command queue depth (power of 2, >=2)

Ports:
CLK_50M  input  1  system clock
RST  input  1  synchronous active-high reset
game_state  input  2  0=IDLE 1=PLAY 2=PAUSE 3=OVER (from State_Ctrl)
left_key_press  input  1  one-cycle pulse
right_key_press  input  1  one-cycle pulse
down_key_press  input  1  one-cycle pulse
level_up  input  1  one-cycle pulse from game core
cmd_valid  output  1  command available
cmd_code  output  2  0=LEFT 1=RIGHT 2=DOWN 3=GRAVITY
cmd_ready  input  1  game core accepts command
level  output  4  current level, saturates at 15
overflow  output  1  sticky: key or tick dropped

Behaviour:
- Reset values: cmd_valid=0, cmd_code=0, level=0, overflow=0; FIFO empty, tick counter=0, gravity_pending=0, FSM=IDLE.
- Gravity period:
  - period = max(TICK_DIV - level*LEVEL_STEP, MIN_DIV), computed in 32-bit unsigned arithmetic.
  - No underflow: if level*LEVEL_STEP >= TICK_DIV - MIN_DIV, the result is MIN_DIV.
  - Registered; takes effect one cycle after a level change.
- Tick counter:
  - Increments only while game_state==PLAY.
  - When count >= period-1: counter->0 and gravity_pending<=1. The >= compare covers a period shrink mid-count.
  - If gravity_pending is already 1 when a tick fires, overflow<=1 (tick lost; pending remains 1).
- Key enqueue:
  - Only in PLAY; presses in other states are ignored and do not set overflow.
  - At most one key per cycle, priority DOWN > LEFT > RIGHT.
  - Other same-cycle pulses are dropped and set overflow.
  - Enqueue into a full FIFO drops the key and sets overflow.
  - Enqueue and dequeue in the same cycle are legal even when full; the key is stored.
- FSM:
  - IDLE: if PLAY and (gravity_pending or FIFO non-empty), select a command. GRAVITY wins over the FIFO head. Register cmd_code, set cmd_valid=1 next cycle, go to ISSUE.
  - Selection clears the source immediately: pop FIFO or clear gravity_pending.
  - ISSUE: cmd_valid and cmd_code held stable until cmd_ready. On cmd_valid&cmd_ready, cmd_valid<=0 and go to IDLE.
  - Minimum one idle cycle between commands, so the peak rate is one command per 2 cycles.
  - Latency from key pulse (FIFO empty, no gravity pending) to cmd_valid: 2 cycles.
- Leaving PLAY (any other game_state):
  - cmd_valid<=0 and FSM<=IDLE next cycle; an unaccepted command is discarded.
  - FIFO is flushed, gravity_pending cleared, counter held.
- PAUSE only: the counter holds its value and resumes on return to PLAY. The FIFO is still flushed.
- IDLE or OVER: counter<=0.
- Transition IDLE->PLAY: level<=0 and overflow<=0.
- level_up increments level, saturating at 15. Accepted in any state.
- Reset asserted mid-command: all state returns to reset values on that edge.

Optional Feature:
SOFT_DROP_RESET_EN
- Defined: an accepted DOWN command (valid&ready with cmd_code=2) sets the tick counter to 0 and clears gravity_pending in the same cycle, so a soft drop is never immediately followed by a gravity drop.
- Undefined: the counter free-runs regardless of DOWN commands.

Decomposition:
- Package block_killer_pkg holds:
  - cmd code constants (CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_GRAVITY);
  - game_state encodings (GS_IDLE, GS_PLAY, GS_PAUSE, GS_OVER);
  - FSM state constants.
- One sub-module, cmd_fifo: synchronous FIFO, 2-bit data, FIFO_DEPTH entries, with push/pop/full/empty/flush.

Test Plan:
- TICK_DIV=10, MIN_DIV=4, LEVEL_STEP=2, cmd_ready=1, PLAY, no keys -> GRAVITY cmd_valid pulse every 10 cycles; after 3 level_up -> every 4 cycles; after 12 level_up -> level=12, still every 4 cycles.
- Left, right, down pulses on 3 consecutive cycles, cmd_ready=0 for 20 cycles then 1 -> cmd_code stays LEFT while valid; accepted order LEFT, RIGHT, DOWN; overflow=0.
- 5 left pulses with cmd_ready=0 -> first pops into ISSUE, 4 queued, 5th accepted; a 6th pulse sets overflow=1 and is dropped.
- Left and down pulsed in the same cycle -> DOWN issued, overflow=1. Gravity tick and queued key pending together -> GRAVITY issued first.
- PAUSE while cmd_valid=1 -> cmd_valid=0 next cycle, FIFO empty. Counter value preserved across PAUSE->PLAY; first GRAVITY arrives at the remaining count.
- SOFT_DROP_RESET_EN defined, TICK_DIV=10: DOWN accepted at count 7 -> next GRAVITY 10 cycles later. Undefined -> next GRAVITY 3 cycles later.
